cache_writeback_fsm: RTL and testbench
======================================

# cache_writeback_fsm

Write-back engine for the 16-bit cache: the writer-side counterpart of the cache fill FSM. On an eviction request it walks all eight 16-bit words of one block out of the data array and writes them to main memory, honouring a memory stall. It then pulses completion so the cache can clear the dirty bit and start the fill. It sits between the cache controller/`DataArray` read port and the memory write port; fill and write-back never overlap.

## Interface
Parameters:
- `ADDR_W`, 16, byte address width
- `DATA_W`, 16, word width
- `WORDS`, 8, words per block (power of two; offset width = log2(WORDS)+1 bits, bit 0 is byte select)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `evict_req`  in  1  start write-back of the block named by `evict_address`; sampled only in IDLE
- `evict_address`  in  ADDR_W  any address in the victim block (tag + set); low 4 bits ignored
- `cache_word_sel`  out  3  word index driven to the `DataArray` word decoder
- `cache_data`  in  DATA_W  combinational `DataArray` output for the selected word
- `mem_address`  out  ADDR_W  memory write address
- `mem_data`  out  DATA_W  memory write data
- `mem_write`  out  1  memory write strobe (also the memory enable)
- `mem_stall`  in  1  memory not accepting; hold address, data and strobe
- `fsm_busy`  out  1  high from the request-accept edge until the return to IDLE
- `evict_done`  out  1  one-cycle completion pulse; the cache clears the dirty/valid metadata on it

## Operation
- States are IDLE, XFER and DONE; there is a 3-bit word counter `cnt`.
- IDLE:
  - On `evict_req`=1 at a rising edge, latch `base` = `evict_address[15:4]`, clear `cnt`, and go to XFER.
  - Otherwise remain in IDLE.
- XFER:
  - `cache_word_sel` = `cnt`.
  - `mem_address` = {`base`, `cnt`, 1'b0}.
  - `mem_data` = `cache_data` (pass-through, no register).
  - `mem_write` = 1.
  - A word is accepted on an edge where `mem_stall`=0. Acceptance increments `cnt`; if `cnt`=7, go to DONE instead.
  - While `mem_stall`=1, `cnt` and all outputs hold.
- DONE:
  - `evict_done` = 1 and `mem_write` = 0.
  - Unconditionally go to IDLE on the next edge.
- `evict_req` while not in IDLE is ignored; it is not queued.
- `evict_req` held high across DONE→IDLE starts a new write-back on the first IDLE edge.
- `evict_address` is don't-care after the accept edge, because `base` is latched.
- Words are always written in ascending order 0..7. There is no wrap-around; `cnt` never rolls over inside XFER.

## Timing
- Reset values (asynchronous, immediate):
  - State = IDLE, `cnt` = 0, `base` = 0.
  - `mem_write` = 0, `evict_done` = 0, `fsm_busy` = 0.
  - `cache_word_sel` = 0, `mem_address` = 0.
- `mem_data` follows `cache_data`, gated to 0 when `mem_write` = 0.
- Latency with no stalls:
  - Request accepted at edge N.
  - Word k is written in cycle N+1+k.
  - `evict_done` is high in cycle N+9.
  - IDLE from edge N+10.
- Total occupancy is 9 cycles plus the number of stall cycles.
- `fsm_busy` is high in cycles N+1 .. N+9 inclusive; it is a registered state decode, not a combinational function of `evict_req`.
- `mem_stall` is sampled only in XFER and ignored elsewhere.
- Reset asserted mid-transfer abandons the block immediately. No `evict_done` is produced, and memory holds a partially written block; the controller must treat the line as lost.

## Structure
- Shared package `cache_pkg`:
  - State enum (IDLE, XFER, DONE).
  - `WORDS_PER_BLOCK` = 8 and `BLOCK_OFFSET_W` = 4.
  - Field slices `TAG_HI`/`TAG_LO` (15/11) and `SET_HI`/`SET_LO` (10/4). These slices are shared with the fill FSM and the cache top.
- One natural sub-module: `wb_word_counter`, a 3-bit counter with enable (accept) and synchronous clear (on the request-accept edge) that flags the terminal count at 7. Everything else lives in the FSM module.

## Test plan
- Reset, then no request: all outputs 0 and `fsm_busy` = 0 for 20 cycles.
- `evict_address`=0x5A37, no stall, cache word k returns 0x1000+k:
  - Exactly 8 `mem_write` cycles, at addresses 0x5A30, 0x5A32, …, 0x5A3E, with data 0x1000..0x1007.
  - `evict_done` for one cycle exactly 9 cycles after the accept edge.
- Same request with `mem_stall` high for 3 cycles during word 4:
  - Address 0x5A38 and data 0x1004 are held steady for 4 cycles.
  - Total busy = 12 cycles and no word is duplicated.
- `evict_req` pulsed again at word 2 with `evict_address`=0xFFF0: the second request is ignored, and every address stays in block 0x5A3x.
- `rst_n` dropped at word 5:
  - Outputs go to 0 without waiting for a clock edge.
  - No `evict_done` is produced.
  - After release, a new request at 0x0000 writes 0x0000..0x000E correctly.
- `evict_req` held high continuously: back-to-back write-backs 10 cycles apart, and `fsm_busy` low for exactly one cycle between them.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache definitions: write-back FSM states and address field slices
// used by the fill FSM, write-back FSM and cache top.
package cache_pkg;
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_XFER = 2'd1,
    WB_DONE = 2'd2
  } wb_state_e;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFFSET_W  = 4;

  localparam int TAG_HI = 15;
  localparam int TAG_LO = 11;
  localparam int SET_HI = 10;
  localparam int SET_LO = 4;
endpackage

// File: rtl/cache_writeback_fsm_if.sv
// Write-back engine bus: eviction request, DataArray read port, memory write port.
// master = the write-back engine, slave = controller/array/memory side.
interface cache_writeback_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
);
  localparam int SEL_W = $clog2(WORDS);

  logic              evict_req;
  logic [ADDR_W-1:0] evict_address;
  logic [SEL_W-1:0]  cache_word_sel;
  logic [DATA_W-1:0] cache_data;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_write;
  logic              mem_stall;
  logic              fsm_busy;
  logic              evict_done;

  modport master (
    input  evict_req, evict_address, cache_data, mem_stall,
    output cache_word_sel, mem_address, mem_data, mem_write, fsm_busy, evict_done
  );

  modport slave (
    output evict_req, evict_address, cache_data, mem_stall,
    input  cache_word_sel, mem_address, mem_data, mem_write, fsm_busy, evict_done
  );
endinterface

// File: rtl/cache_writeback_fsm_word_counter.sv
// Block word counter: cleared when a write-back starts, advanced per accepted
// word, saturating at the last word so the FSM can see the terminal count.
module wb_word_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  assign tc = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/cache_writeback_fsm.sv
// Cache block write-back engine: streams the eight words of a victim block from
// the DataArray to memory in ascending order, stalling with memory, then pulses done.
module cache_writeback_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = WORDS_PER_BLOCK
) (
  input logic                  clk,
  input logic                  rst_n,
  cache_writeback_fsm_if.master bus
);
  localparam int CNT_W  = $clog2(WORDS);
  localparam int BASE_W = ADDR_W - BLOCK_OFFSET_W;

  localparam logic [1:0] S_IDLE = 2'(WB_IDLE);
  localparam logic [1:0] S_XFER = 2'(WB_XFER);
  localparam logic [1:0] S_DONE = 2'(WB_DONE);

  logic [1:0]        state;
  logic [BASE_W-1:0] base;
  logic [CNT_W-1:0]  cnt;
  logic              accept_req, word_acc, last_word, xfer;

  // Offset bits of the request address carry no information for a whole-block walk.
  logic unused_offset;
  assign unused_offset = ^bus.evict_address[BLOCK_OFFSET_W-1:0];

  assign xfer       = (state == S_XFER);
  assign accept_req = (state == S_IDLE) && bus.evict_req;
  assign word_acc   = xfer && !bus.mem_stall;

  wb_word_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept_req),
    .en    (word_acc),
    .cnt   (cnt),
    .tc    (last_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      base  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.evict_req) begin
          state <= S_XFER;
          base  <= bus.evict_address[ADDR_W-1:BLOCK_OFFSET_W];
        end
        S_XFER: if (!bus.mem_stall && last_word) state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // All outputs decode registered state, so reset clears them without a clock.
  assign bus.mem_write      = xfer;
  assign bus.evict_done     = (state == S_DONE);
  assign bus.fsm_busy       = (state != S_IDLE);
  assign bus.cache_word_sel = xfer ? cnt : '0;
  assign bus.mem_address    = xfer ? {base, cnt, 1'b0} : '0;
  assign bus.mem_data       = xfer ? bus.cache_data : '0;
endmodule

// File: tb/tb_cache_writeback_fsm.sv
// Directed bench for cache_writeback_fsm: a block-level model (words-written
// count per active write-back) checked every cycle, plus literal expectations.
module tb_cache_writeback_fsm;
  localparam int ADDR_W = 16, DATA_W = 16, WORDS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_writeback_fsm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus();

  cache_writeback_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] cache_words [8];
  assign bus.cache_data = cache_words[bus.cache_word_sel];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: an active write-back with m_n words already written (0..8).
  bit          m_act  = 1'b0;
  int          m_n    = 0;
  logic [11:0] m_base = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0; m_n = 0; m_base = '0;
    end else if (!m_act) begin
      if (bus.evict_req) begin
        m_act = 1'b1; m_n = 0; m_base = bus.evict_address[15:4];
      end
    end else if (m_n == WORDS) m_act = 1'b0;
    else if (!bus.mem_stall) m_n++;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_busy, n_write, n_done, n_hold, done_cyc, low_run;
  bit prev_busy = 1'b0;
  logic [15:0] log_a[$];
  logic [15:0] log_d[$];
  int rises[$];
  int runs[$];

  always @(negedge clk) begin
    bit w;
    w = m_act && (m_n < WORDS);
    chk("busy",  32'(bus.fsm_busy),   32'(m_act));
    chk("write", 32'(bus.mem_write),  32'(w));
    chk("done",  32'(bus.evict_done), 32'(m_act && m_n == WORDS));
    chk("addr",  32'(bus.mem_address), w ? 32'({m_base, 4'h0} + 16'(2 * m_n)) : 32'd0);
    chk("sel",   32'(bus.cache_word_sel), w ? 32'(m_n) : 32'd0);
    chk("data",  32'(bus.mem_data), w ? 32'(cache_words[m_n[2:0]]) : 32'd0);

    if (bus.fsm_busy)  n_busy++;
    if (bus.mem_write) n_write++;
    if (bus.evict_done) begin n_done++; done_cyc = cyc; end
    if (bus.mem_write && !bus.mem_stall) begin
      log_a.push_back(bus.mem_address);
      log_d.push_back(bus.mem_data);
    end
    if (bus.mem_write && bus.mem_address == 16'h5A38 && bus.mem_data == 16'h1004) n_hold++;
    if (bus.fsm_busy && !prev_busy) rises.push_back(cyc);
    if (!bus.fsm_busy) low_run++;
    else begin
      if (low_run > 0) runs.push_back(low_run);
      low_run = 0;
    end
    prev_busy = bus.fsm_busy;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clear();
    n_busy = 0; n_write = 0; n_done = 0; n_hold = 0; done_cyc = 0; low_run = 0;
    log_a.delete(); log_d.delete(); rises.delete(); runs.delete();
  endtask

  int acc_cyc;
  task automatic start_req(input logic [15:0] a);
    bus.evict_req = 1'b1; bus.evict_address = a;
    tick();
    acc_cyc = cyc;
    bus.evict_req = 1'b0;
    bus.evict_address = 16'hDEAD;
  endtask

  task automatic wait_done();
    int d0;
    bit seen;
    d0 = n_done; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (n_done > d0) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    bus.evict_req = 1'b0; bus.evict_address = '0; bus.mem_stall = 1'b0;
    for (int k = 0; k < 8; k++) cache_words[k] = 16'h1000 + 16'(k);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset
    clear();
    repeat (20) tick();
    chk("idle_busy", 32'(n_busy), 32'd0);
    chk("idle_write", 32'(n_write), 32'd0);
    chk("idle_done", 32'(n_done), 32'd0);

    // Plain write-back of block 0x5A3x
    clear();
    start_req(16'h5A37);
    wait_done();
    chk("wb_words", 32'(log_a.size()), 32'd8);
    for (int k = 0; k < 8 && k < log_a.size(); k++) begin
      chk("wb_addr", 32'(log_a[k]), 32'(16'h5A30 + 16'(2 * k)));
      chk("wb_data", 32'(log_d[k]), 32'(16'h1000 + 16'(k)));
    end
    chk("wb_done_cnt", 32'(n_done), 32'd1);
    chk("wb_done_lat", 32'(done_cyc - acc_cyc + 1), 32'd9);
    chk("wb_busy", 32'(n_busy), 32'd9);
    chk("wb_writes", 32'(n_write), 32'd8);

    // Three stall cycles on word 4
    clear();
    start_req(16'h5A37);
    repeat (4) tick();
    bus.mem_stall = 1'b1;
    repeat (3) tick();
    bus.mem_stall = 1'b0;
    wait_done();
    chk("stall_hold", 32'(n_hold), 32'd4);
    chk("stall_words", 32'(log_a.size()), 32'd8);
    for (int k = 0; k < 8 && k < log_a.size(); k++)
      chk("stall_addr", 32'(log_a[k]), 32'(16'h5A30 + 16'(2 * k)));
    chk("stall_busy", 32'(n_busy), 32'd12);
    chk("stall_done_lat", 32'(done_cyc - acc_cyc + 1), 32'd12);

    // Second request mid-transfer is dropped
    clear();
    start_req(16'h5A37);
    repeat (2) tick();
    bus.evict_req = 1'b1; bus.evict_address = 16'hFFF0;
    tick();
    bus.evict_req = 1'b0;
    wait_done();
    chk("ign_words", 32'(log_a.size()), 32'd8);
    for (int k = 0; k < log_a.size(); k++)
      chk("ign_block", 32'(log_a[k][15:4]), 32'h5A3);
    chk("ign_done", 32'(n_done), 32'd1);
    chk("ign_busy", 32'(n_busy), 32'd9);

    // Reset during word 5
    clear();
    start_req(16'h5A37);
    repeat (5) tick();
    chk("rst_pre_words", 32'(log_a.size()), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_write", 32'(bus.mem_write), 32'd0);
    chk("rst_busy", 32'(bus.fsm_busy), 32'd0);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_sel", 32'(bus.cache_word_sel), 32'd0);
    chk("rst_data", 32'(bus.mem_data), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_no_done", 32'(n_done), 32'd0);
    clear();
    start_req(16'h0000);
    wait_done();
    chk("post_rst_words", 32'(log_a.size()), 32'd8);
    for (int k = 0; k < 8 && k < log_a.size(); k++) begin
      chk("post_rst_addr", 32'(log_a[k]), 32'(2 * k));
      chk("post_rst_data", 32'(log_d[k]), 32'(16'h1000 + 16'(k)));
    end

    // Request held high: back-to-back write-backs
    clear();
    bus.evict_req = 1'b1; bus.evict_address = 16'h1230;
    repeat (25) tick();
    bus.evict_req = 1'b0;
    repeat (15) tick();
    chk("b2b_count", 32'(rises.size()), 32'd3);
    chk("b2b_done", 32'(n_done), 32'd3);
    if (rises.size() >= 3) begin
      chk("b2b_gap1", 32'(rises[1] - rises[0]), 32'd10);
      chk("b2b_gap2", 32'(rises[2] - rises[1]), 32'd10);
    end
    chk("b2b_runs", 32'(runs.size()), 32'd3);
    if (runs.size() >= 3) begin
      chk("b2b_low1", 32'(runs[1]), 32'd1);
      chk("b2b_low2", 32'(runs[2]), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
